// File: rtl/analysis_pkg.sv
// Shared widths, FSM state encoding and the running-max candidate type
// used by the frequency-analysis scheduler.
package analysis_pkg;

  localparam int NUM_BINS    = 16;
  localparam int BIN_W       = 4;
  localparam int AMP_W       = 32;
  localparam int WORD_W      = 32;
  localparam int FRAME_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT,
    FINISH
  } an_state_t;

  // Amplitude in the upper bits so a plain vector compare orders by amplitude
  // first and breaks ties toward the higher bin index.
  typedef struct packed {
    logic [AMP_W-1:0] amp;
    logic [BIN_W-1:0] idx;
  } max_cand_t;

endpackage

// File: rtl/amp_sq.sv
// Combinational squared magnitude of one FFT bin: re*re + im*im, unsigned.
module amp_sq
  import analysis_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [AMP_W-1:0]  o_amp
);

  logic signed [15:0] w_re;
  logic signed [15:0] w_im;
  logic signed [31:0] w_re_sq;
  logic signed [31:0] w_im_sq;

  assign w_re    = i_word[31:16];
  assign w_im    = i_word[15:0];
  assign w_re_sq = w_re * w_re;
  assign w_im_sq = w_im * w_im;

  // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
  assign o_amp = $unsigned(w_re_sq) + $unsigned(w_im_sq);

endmodule

// File: rtl/analysis_scheduler.sv
// Captures one 16-bin FFT frame per handshake, scans it one bin per cycle
// through a shared squared-magnitude unit and reports the peak bin.
module analysis_scheduler
  import analysis_pkg::*;
#(
  parameter int MAX_FRAMES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fft_valid,
  output logic                   fft_ready,
  input  logic [WORD_W-1:0]      fft_d0,
  input  logic [WORD_W-1:0]      fft_d1,
  input  logic [WORD_W-1:0]      fft_d2,
  input  logic [WORD_W-1:0]      fft_d3,
  input  logic [WORD_W-1:0]      fft_d4,
  input  logic [WORD_W-1:0]      fft_d5,
  input  logic [WORD_W-1:0]      fft_d6,
  input  logic [WORD_W-1:0]      fft_d7,
  input  logic [WORD_W-1:0]      fft_d8,
  input  logic [WORD_W-1:0]      fft_d9,
  input  logic [WORD_W-1:0]      fft_d10,
  input  logic [WORD_W-1:0]      fft_d11,
  input  logic [WORD_W-1:0]      fft_d12,
  input  logic [WORD_W-1:0]      fft_d13,
  input  logic [WORD_W-1:0]      fft_d14,
  input  logic [WORD_W-1:0]      fft_d15,
  output logic                   done,
  output logic [BIN_W-1:0]       freq,
  output logic [AMP_W-1:0]       peak_amp,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   all_done
);

  an_state_t              r_state;
  logic [WORD_W-1:0]      r_buf [NUM_BINS];
  logic [BIN_W-1:0]       r_idx;
  max_cand_t              r_max;
  logic                   r_done;
  logic [BIN_W-1:0]       r_freq;
  logic [AMP_W-1:0]       r_peak_amp;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic [WORD_W-1:0]      w_in [NUM_BINS];
  logic [WORD_W-1:0]      w_word;
  logic [AMP_W-1:0]       w_amp;
  logic                   w_accept;
  max_cand_t              w_cand;
  max_cand_t              w_best;

  assign w_in[0]  = fft_d0;
  assign w_in[1]  = fft_d1;
  assign w_in[2]  = fft_d2;
  assign w_in[3]  = fft_d3;
  assign w_in[4]  = fft_d4;
  assign w_in[5]  = fft_d5;
  assign w_in[6]  = fft_d6;
  assign w_in[7]  = fft_d7;
  assign w_in[8]  = fft_d8;
  assign w_in[9]  = fft_d9;
  assign w_in[10] = fft_d10;
  assign w_in[11] = fft_d11;
  assign w_in[12] = fft_d12;
  assign w_in[13] = fft_d13;
  assign w_in[14] = fft_d14;
  assign w_in[15] = fft_d15;

  assign fft_ready = (r_state == IDLE);
  assign all_done  = (r_state == FINISH);
  assign done      = r_done;
  assign freq      = r_freq;
  assign peak_amp  = r_peak_amp;
  assign frame_cnt = r_frame_cnt;

  assign w_accept = fft_valid && (r_state == IDLE);
  assign w_word   = r_buf[r_idx];

  amp_sq u_amp_sq (
    .i_word (w_word),
    .o_amp  (w_amp)
  );

  assign w_cand.amp = w_amp;
  assign w_cand.idx = r_idx;
  assign w_best     = (w_cand >= r_max) ? w_cand : r_max;

  // Frame buffer holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NUM_BINS; k++) begin
        r_buf[k] <= w_in[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_max       <= '0;
      r_done      <= 1'b0;
      r_freq      <= '0;
      r_peak_amp  <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state     <= SCAN;
            r_idx       <= '0;
            r_max       <= '0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        SCAN: begin
          r_max <= w_best;
          r_idx <= r_idx + 1'b1;
          if (r_idx == BIN_W'(NUM_BINS - 1)) begin
            r_state    <= REPORT;
            r_done     <= 1'b1;
            r_freq     <= w_best.idx;
            r_peak_amp <= w_best.amp;
          end
        end
        REPORT: begin
          r_done <= 1'b0;
          if (r_frame_cnt == FRAME_CNT_W'(MAX_FRAMES)) begin
            r_state <= FINISH;
          end else begin
            r_state <= IDLE;
          end
        end
        FINISH: begin
          r_done <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_analysis_scheduler.sv
// Self-checking bench for analysis_scheduler: directed frames from the test
// plan plus randomized frames checked against a behavioural peak model.
module tb_analysis_scheduler;

  localparam int MAXF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic        fft_ready;
  logic [31:0] drv [16];
  logic        done;
  logic [3:0]  freq;
  logic [31:0] peak_amp;
  logic [5:0]  frame_cnt;
  logic        all_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  analysis_scheduler #(.MAX_FRAMES(MAXF)) dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_ready (fft_ready),
    .fft_d0    (drv[0]),
    .fft_d1    (drv[1]),
    .fft_d2    (drv[2]),
    .fft_d3    (drv[3]),
    .fft_d4    (drv[4]),
    .fft_d5    (drv[5]),
    .fft_d6    (drv[6]),
    .fft_d7    (drv[7]),
    .fft_d8    (drv[8]),
    .fft_d9    (drv[9]),
    .fft_d10   (drv[10]),
    .fft_d11   (drv[11]),
    .fft_d12   (drv[12]),
    .fft_d13   (drv[13]),
    .fft_d14   (drv[14]),
    .fft_d15   (drv[15]),
    .done      (done),
    .freq      (freq),
    .peak_amp  (peak_amp),
    .frame_cnt (frame_cnt),
    .all_done  (all_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Peak = largest re^2+im^2; scanning upward with >= keeps the highest bin on ties.
  task automatic modelPeak(output logic [3:0] bin, output logic [31:0] amp);
    longint best;
    shortint re;
    shortint im;
    longint a;
    best = -1;
    bin = '0;
    for (int k = 0; k < 16; k++) begin
      re = drv[k][31:16];
      im = drv[k][15:0];
      a = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (a >= best) begin
        best = a;
        bin = 4'(k);
      end
    end
    amp = 32'(best);
  endtask

  task automatic setFrame(input logic [31:0] background);
    for (int k = 0; k < 16; k++) drv[k] = background;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    fft_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Hands the current drv frame over, waits for done and checks the report.
  task automatic applyStimulus(input string tag, input int expCnt, input bit last, input bit disturb);
    logic [3:0]  eBin;
    logic [31:0] eAmp;
    int          n;
    bit          seen;
    @(negedge clk);
    fft_valid = 1'b1;
    checkOutput({tag, "_ready"}, 32'(fft_ready), 32'd1);
    modelPeak(eBin, eAmp);
    @(posedge clk);
    #1 fft_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n = i;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (disturb) begin
        fft_valid = i[0];
        for (int k = 0; k < 16; k++) drv[k] = $urandom;
      end
    end
    fft_valid = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(n), 32'd17);
    checkOutput({tag, "_freq"}, 32'(freq), 32'(eBin));
    checkOutput({tag, "_amp"}, peak_amp, eAmp);
    checkOutput({tag, "_cnt"}, 32'(frame_cnt), 32'(expCnt));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(fft_ready), last ? 32'd0 : 32'd1);
    checkOutput({tag, "_all_done"}, 32'(all_done), last ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [3:0]  eBin;
    logic [31:0] eAmp;
    int          doneCyc [3];
    bit          seen;

    setFrame(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(fft_ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_freq", 32'(freq), 32'd0);
    checkOutput("rst_amp", peak_amp, 32'd0);
    checkOutput("rst_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_all_done", 32'(all_done), 32'd0);
    rst = 1'b1;

    $display("[TB] single peak at bin 5");
    setFrame(32'h0);
    drv[5] = {16'sd100, 16'sd0};
    applyStimulus("single", 1, 1'b0, 1'b0);
    checkOutput("single_freq_const", 32'(freq), 32'd5);
    checkOutput("single_amp_const", peak_amp, 32'd10000);

    $display("[TB] tie between bins 3 and 12");
    setFrame({16'sd1, 16'sd1});
    drv[3]  = {-16'sd7, 16'sd7};
    drv[12] = {-16'sd7, 16'sd7};
    applyStimulus("tie", 2, 1'b0, 1'b0);
    checkOutput("tie_freq_const", 32'(freq), 32'd12);
    checkOutput("tie_amp_const", peak_amp, 32'd98);

    $display("[TB] reset mid-scan");
    setFrame(32'h0);
    drv[9] = 32'h8000_8000;
    @(negedge clk);
    fft_valid = 1'b1;
    @(posedge clk);
    #1 fft_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(fft_ready), 32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_freq", 32'(freq), 32'd0);
    checkOutput("midrst_amp", peak_amp, 32'd0);
    checkOutput("midrst_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("midrst_all_done", 32'(all_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] extreme and all-zero frames");
    applyStimulus("extreme", 1, 1'b0, 1'b0);
    checkOutput("extreme_freq_const", 32'(freq), 32'd9);
    checkOutput("extreme_amp_const", peak_amp, 32'h8000_0000);
    setFrame(32'h0);
    applyStimulus("zero", 2, 1'b0, 1'b0);
    checkOutput("zero_freq_const", 32'(freq), 32'd15);
    checkOutput("zero_amp_const", peak_amp, 32'd0);

    $display("[TB] valid toggled and data changed during scan");
    setFrame({16'sd3, -16'sd2});
    drv[6] = {16'sd200, 16'sd50};
    applyStimulus("disturb", 3, 1'b1, 1'b1);
    checkOutput("disturb_freq_const", 32'(freq), 32'd6);
    fft_valid = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("finish_cnt_hold", 32'(frame_cnt), 32'd3);
    checkOutput("finish_ready", 32'(fft_ready), 32'd0);
    checkOutput("finish_all_done", 32'(all_done), 32'd1);
    fft_valid = 1'b0;

    $display("[TB] back-to-back with valid held high");
    doReset();
    setFrame({16'sd2, 16'sd2});
    drv[1] = {16'sd500, 16'sd0};
    @(negedge clk);
    fft_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      modelPeak(eBin, eAmp);
      seen = 1'b0;
      doneCyc[f] = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          doneCyc[f] = cyc;
          break;
        end
      end
      checkOutput("b2b_done_seen", 32'(seen), 32'd1);
      checkOutput("b2b_freq", 32'(freq), 32'(f + 1));
      checkOutput("b2b_model_freq", 32'(freq), 32'(eBin));
      checkOutput("b2b_amp", peak_amp, eAmp);
      if (f > 0) checkOutput("b2b_spacing", 32'(doneCyc[f] - doneCyc[f-1]), 32'd18);
      setFrame({16'sd2, 16'sd2});
      drv[f + 2] = {16'sd500, 16'sd0};
    end
    repeat (6) @(negedge clk);
    checkOutput("b2b_cnt", 32'(frame_cnt), 32'd3);
    checkOutput("b2b_all_done", 32'(all_done), 32'd1);
    checkOutput("b2b_ready", 32'(fft_ready), 32'd0);
    fft_valid = 1'b0;

    $display("[TB] randomized frames");
    for (int rnd = 0; rnd < 3; rnd++) begin
      doReset();
      for (int f = 0; f < 3; f++) begin
        for (int k = 0; k < 16; k++) drv[k] = $urandom;
        if ($urandom_range(0, 1) == 1) drv[$urandom_range(0, 15)] = drv[$urandom_range(0, 15)];
        repeat ($urandom_range(0, 3)) @(negedge clk);
        applyStimulus("random", f + 1, f == 2, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
